// File: rtl/ddr5_req_queue_pkg.sv
// Shared DDR5 request types: op codes, decoded request layout and field widths.
// The struct widths track the REQ_* localparams; queue/map parameters default to them.
package ddr5_req_queue_pkg;

    localparam int REQ_ADDR_W   = 36;
    localparam int REQ_TIME_W   = 64;
    localparam int REQ_CORE_W   = 4;
    localparam int REQ_CH_BITS  = 1;
    localparam int REQ_ROW_BITS = 16;

    localparam int BYTE_SEL_W = 2;
    localparam int COL_LOW_W  = 4;
    localparam int BG_W       = 3;
    localparam int BANK_W     = 2;
    localparam int COL_HIGH_W = 6;

    typedef enum logic [1:0] {
        OP_READ   = 2'd0,
        OP_WRITE  = 2'd1,
        OP_IFETCH = 2'd2
    } op_t;

    typedef struct packed {
        logic [REQ_TIME_W-1:0]   req_time;
        logic [REQ_CORE_W-1:0]   core;
        op_t                     op;
        logic [REQ_ADDR_W-1:0]   addr;
        logic [BYTE_SEL_W-1:0]   byte_sel;
        logic [COL_LOW_W-1:0]    col_low;
        logic [REQ_CH_BITS-1:0]  channel;
        logic [BG_W-1:0]         bank_group;
        logic [BANK_W-1:0]       bank;
        logic [COL_HIGH_W-1:0]   col_high;
        logic [REQ_ROW_BITS-1:0] row;
    } mapped_req_t;

    localparam int MAPPED_W = $bits(mapped_req_t);

endpackage

// File: rtl/ddr5_addr_map.sv
// Combinational DDR5 address decode of a trace request into mapped_req_t.
// Field order from the LSB: byte_sel, col_low, channel, bank_group, bank, col_high, row.
module ddr5_addr_map
    import ddr5_req_queue_pkg::*;
#(
    parameter int ADDR_W   = REQ_ADDR_W,
    parameter int CH_BITS  = REQ_CH_BITS,
    parameter int ROW_BITS = REQ_ROW_BITS
) (
    input  logic [REQ_TIME_W-1:0] i_time,
    input  logic [REQ_CORE_W-1:0] i_core,
    input  logic [1:0]            i_op,
    input  logic [ADDR_W-1:0]     i_addr,
    output mapped_req_t           o_req
);

    localparam int CH_LSB   = BYTE_SEL_W + COL_LOW_W;
    localparam int BG_LSB   = CH_LSB + CH_BITS;
    localparam int BANK_LSB = BG_LSB + BG_W;
    localparam int COLH_LSB = BANK_LSB + BANK_W;
    localparam int ROW_LSB  = COLH_LSB + COL_HIGH_W;

    always_comb begin
        o_req            = '0;
        o_req.req_time   = i_time;
        o_req.core       = i_core;
        o_req.op         = op_t'(i_op);
        o_req.addr       = i_addr;
        o_req.byte_sel   = i_addr[0 +: BYTE_SEL_W];
        o_req.col_low    = i_addr[BYTE_SEL_W +: COL_LOW_W];
        o_req.channel    = i_addr[CH_LSB +: CH_BITS];
        o_req.bank_group = i_addr[BG_LSB +: BG_W];
        o_req.bank       = i_addr[BANK_LSB +: BANK_W];
        o_req.col_high   = i_addr[COLH_LSB +: COL_HIGH_W];
        o_req.row        = i_addr[ROW_LSB +: ROW_BITS];
    end

endmodule

// File: rtl/ddr5_req_queue.sv
// Trace request queue: one time-gated pending register feeding an oldest-first FIFO,
// with per-channel occupancy counts and a saturating cycle counter.
module ddr5_req_queue
    import ddr5_req_queue_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = REQ_ADDR_W,
    parameter int TIME_W   = REQ_TIME_W,
    parameter int CORE_W   = REQ_CORE_W,
    parameter int CH_BITS  = REQ_CH_BITS,
    parameter int ROW_BITS = REQ_ROW_BITS,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1,
    localparam int NUM_CH  = 2 ** CH_BITS
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [TIME_W-1:0]      in_time,
    input  logic [CORE_W-1:0]      in_core,
    input  logic [1:0]             in_op,
    input  logic [ADDR_W-1:0]      in_addr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [MAPPED_W-1:0]    out_req,
    output logic [CW-1:0]          count,
    output logic [NUM_CH*CW-1:0]   ch_count,
    output logic                   full,
    output logic                   empty,
    output logic [TIME_W-1:0]      cycle_count
);

    mapped_req_t          w_mapped;
    mapped_req_t          w_head;
    mapped_req_t          r_pend;
    mapped_req_t          r_mem [DEPTH];
    logic                 r_pend_valid;
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic [CW-1:0]        r_ch_cnt [NUM_CH];
    logic [TIME_W-1:0]    r_cycle;
    logic                 w_accept;
    logic                 w_release;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;

    ddr5_addr_map #(
        .ADDR_W   (ADDR_W),
        .CH_BITS  (CH_BITS),
        .ROW_BITS (ROW_BITS)
    ) u_addr_map (
        .i_time (in_time),
        .i_core (in_core),
        .i_op   (in_op),
        .i_addr (in_addr),
        .o_req  (w_mapped)
    );

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_head    = r_mem[r_rd_ptr];
    assign w_pop     = out_valid && out_ready;
    assign w_release = r_pend_valid && (r_pend.req_time <= r_cycle) && (!w_full || w_pop);
    assign w_push    = w_release;
    assign in_ready  = !r_pend_valid || w_release;
    assign w_accept  = in_valid && in_ready;

    assign out_valid   = (r_count != '0);
    assign out_req     = out_valid ? w_head : '0;
    assign count       = r_count;
    assign full        = w_full;
    assign empty       = (r_count == '0);
    assign cycle_count = r_cycle;

    always_comb begin
        ch_count = '0;
        for (int c = 0; c < NUM_CH; c++) ch_count[c*CW +: CW] = r_ch_cnt[c];
    end

    // Storage needs no reset: out_req is masked while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (w_push && !flush) r_mem[r_wr_ptr] <= r_pend;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cycle      <= '0;
            r_pend_valid <= 1'b0;
            r_pend       <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            for (int c = 0; c < NUM_CH; c++) r_ch_cnt[c] <= '0;
        end else begin
            if (r_cycle != '1) r_cycle <= r_cycle + 1'b1;
            if (flush) begin
                r_pend_valid <= 1'b0;
                r_wr_ptr     <= '0;
                r_rd_ptr     <= '0;
                r_count      <= '0;
                for (int c = 0; c < NUM_CH; c++) r_ch_cnt[c] <= '0;
            end else begin
                if (w_accept) begin
                    r_pend       <= w_mapped;
                    r_pend_valid <= 1'b1;
                end else if (w_release) begin
                    r_pend_valid <= 1'b0;
                end
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
                for (int c = 0; c < NUM_CH; c++) begin
                    if ((w_push && r_pend.channel == CH_BITS'(c)) &&
                        !(w_pop && w_head.channel == CH_BITS'(c)))
                        r_ch_cnt[c] <= r_ch_cnt[c] + 1'b1;
                    else if (!(w_push && r_pend.channel == CH_BITS'(c)) &&
                             (w_pop && w_head.channel == CH_BITS'(c)))
                        r_ch_cnt[c] <= r_ch_cnt[c] - 1'b1;
                end
            end
        end
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(w_push && w_full && !w_pop));
`endif

endmodule

// File: tb/tb_ddr5_req_queue.sv
// Directed bench for ddr5_req_queue: a DEPTH=4 instance for gating/backpressure/flush
// and a default DEPTH=16 instance for per-channel counts; both share stimulus.
module tb_ddr5_req_queue;
    import ddr5_req_queue_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_time = '0;
    logic [3:0]  in_core = '0;
    logic [1:0]  in_op = '0;
    logic [35:0] in_addr = '0;
    logic        out_ready = 1'b0;

    logic                in_ready4, out_valid4, full4, empty4;
    logic [MAPPED_W-1:0] out_req4;
    logic [2:0]          count4;
    logic [5:0]          ch_count4;
    logic [63:0]         cycle_count4;

    logic                in_ready16, out_valid16, full16, empty16;
    logic [MAPPED_W-1:0] out_req16;
    logic [4:0]          count16;
    logic [9:0]          ch_count16;
    logic [63:0]         cycle_count16;

    mapped_req_t q4, q16;
    assign q4  = out_req4;
    assign q16 = out_req16;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    logic use16 = 1'b0;

    always #5 clock = ~clock;

    ddr5_req_queue #(.DEPTH(4)) u_dut4 (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready4), .in_time(in_time),
        .in_core(in_core), .in_op(in_op), .in_addr(in_addr),
        .out_valid(out_valid4), .out_ready(out_ready), .out_req(out_req4),
        .count(count4), .ch_count(ch_count4), .full(full4), .empty(empty4),
        .cycle_count(cycle_count4)
    );

    ddr5_req_queue u_dut16 (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready16), .in_time(in_time),
        .in_core(in_core), .in_op(in_op), .in_addr(in_addr),
        .out_valid(out_valid16), .out_ready(out_ready), .out_req(out_req16),
        .count(count16), .ch_count(ch_count16), .full(full16), .empty(empty16),
        .cycle_count(cycle_count16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        cyc++;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clock);
        #1 reset_n = 1'b1;
        cyc = 0;
    endtask

    // Offer one request, wait (bounded) for in_ready, and return on the cycle after accept.
    task automatic send(input logic [63:0] t, input logic [3:0] core, input logic [1:0] op,
                        input logic [35:0] addr);
        int   n;
        logic rdy;
        in_valid = 1'b1;
        in_time  = t;
        in_core  = core;
        in_op    = op;
        in_addr  = addr;
        n = 0;
        rdy = use16 ? in_ready16 : in_ready4;
        while (!rdy && n < 50) begin
            step();
            n++;
            rdy = use16 ? in_ready16 : in_ready4;
        end
        chk("send_ready", 64'(rdy), 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        // Reset values and default mapping of address 0x40.
        do_reset();
        chk("rst_in_ready", 64'(in_ready4), 64'd1);
        chk("rst_out_valid", 64'(out_valid4), 64'd0);
        chk("rst_out_req", 64'(out_req4 != '0), 64'd0);
        chk("rst_count", 64'(count4), 64'd0);
        chk("rst_ch_count", 64'(ch_count4), 64'd0);
        chk("rst_full", 64'(full4), 64'd0);
        chk("rst_empty", 64'(empty4), 64'd1);
        chk("rst_cycle", cycle_count4, 64'd0);
        send(64'd0, 4'd3, 2'd1, 36'h0_0000_0040);
        chk("map_ov_c1", 64'(out_valid4), 64'd0);
        step();
        chk("map_ov_c2", 64'(out_valid4), 64'd1);
        chk("map_cycle", cycle_count4, 64'd2);
        chk("map_channel", 64'(q4.channel), 64'd1);
        chk("map_others", {q4.byte_sel, q4.col_low, q4.bank_group, q4.bank, q4.col_high, q4.row},
            64'd0);
        chk("map_core", 64'(q4.core), 64'd3);
        chk("map_op", 64'(q4.op), 64'(OP_WRITE));
        chk("map_addr", 64'(q4.addr), 64'h40);
        chk("map_ch_count", 64'(ch_count4), 64'h08);

        // Full-field decode.
        do_reset();
        send(64'd0, 4'd0, 2'd2, 36'h3_FFFF_FFFF);
        step();
        chk("ff_byte_sel", 64'(q4.byte_sel), 64'd3);
        chk("ff_col_low", 64'(q4.col_low), 64'd15);
        chk("ff_channel", 64'(q4.channel), 64'd1);
        chk("ff_bank_group", 64'(q4.bank_group), 64'd7);
        chk("ff_bank", 64'(q4.bank), 64'd3);
        chk("ff_col_high", 64'(q4.col_high), 64'd63);
        chk("ff_row", 64'(q4.row), 64'hFFFF);
        chk("ff_op", 64'(q4.op), 64'(OP_IFETCH));

        // Time gating: in_time 10 accepted at cycle 2.
        do_reset();
        step();
        step();
        chk("tg_cycle2", cycle_count4, 64'd2);
        send(64'd10, 4'd1, 2'd0, 36'h0);
        for (int k = 3; k <= 9; k++) begin
            chk($sformatf("tg_in_ready_c%0d", k), 64'(in_ready4), 64'd0);
            chk($sformatf("tg_out_valid_c%0d", k), 64'(out_valid4), 64'd0);
            step();
        end
        chk("tg_in_ready_c10", 64'(in_ready4), 64'd1);
        chk("tg_out_valid_c10", 64'(out_valid4), 64'd0);
        step();
        chk("tg_out_valid_c11", 64'(out_valid4), 64'd1);
        chk("tg_count_c11", 64'(count4), 64'd1);

        // Full / backpressure on DEPTH=4 with five time-0 requests.
        do_reset();
        for (int i = 1; i <= 5; i++) send(64'd0, 4'(i), 2'd0, 36'(i) << 20);
        chk("bp_count", 64'(count4), 64'd4);
        chk("bp_full", 64'(full4), 64'd1);
        chk("bp_in_ready", 64'(in_ready4), 64'd0);
        chk("bp_head1", 64'(q4.core), 64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_count_swap", 64'(count4), 64'd4);
        chk("bp_full_swap", 64'(full4), 64'd1);
        chk("bp_in_ready_swap", 64'(in_ready4), 64'd1);
        out_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            chk($sformatf("bp_order_%0d", i), 64'(q4.core), 64'(i));
            chk($sformatf("bp_row_%0d", i), 64'(q4.row), 64'(i << 2));
            step();
        end
        out_ready = 1'b0;
        chk("bp_empty", 64'(empty4), 64'd1);

        // Per-channel counts on the DEPTH=16 instance: channels 0,0,1,0,1.
        do_reset();
        use16 = 1'b1;
        send(64'd0, 4'd1, 2'd0, 36'h000);
        send(64'd0, 4'd2, 2'd0, 36'h080);
        send(64'd0, 4'd3, 2'd0, 36'h040);
        send(64'd0, 4'd4, 2'd0, 36'h100);
        send(64'd0, 4'd5, 2'd0, 36'h0C0);
        step();
        chk("ch_count_total", 64'(count16), 64'd5);
        chk("ch_count_c0", 64'(ch_count16[4:0]), 64'd3);
        chk("ch_count_c1", 64'(ch_count16[9:5]), 64'd2);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("ch_pop_c0", 64'(ch_count16[4:0]), 64'd2);
        chk("ch_pop_c1", 64'(ch_count16[9:5]), 64'd2);
        chk("ch_pop_head", 64'(q16.core), 64'd2);
        use16 = 1'b0;

        // Flush with three entries plus a pending request.
        do_reset();
        for (int i = 1; i <= 3; i++) send(64'd0, 4'(i), 2'd0, 36'h40);
        send(64'd1000, 4'd4, 2'd0, 36'h0);
        step();
        chk("fl_pre_count", 64'(count4), 64'd3);
        chk("fl_pre_in_ready", 64'(in_ready4), 64'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_count", 64'(count4), 64'd0);
        chk("fl_empty", 64'(empty4), 64'd1);
        chk("fl_in_ready", 64'(in_ready4), 64'd1);
        chk("fl_ch_count", 64'(ch_count4), 64'd0);
        chk("fl_cycle", cycle_count4, 64'(cyc));
        step();
        chk("fl_cycle_next", cycle_count4, 64'(cyc));

        // Asynchronous reset while a push is in flight.
        do_reset();
        send(64'd0, 4'd1, 2'd0, 36'h40);
        send(64'd0, 4'd2, 2'd0, 36'h40);
        #1 reset_n = 1'b0;
        #1;
        chk("ar_in_ready", 64'(in_ready4), 64'd1);
        chk("ar_out_valid", 64'(out_valid4), 64'd0);
        chk("ar_out_req", 64'(out_req4 != '0), 64'd0);
        chk("ar_count", 64'(count4), 64'd0);
        chk("ar_ch_count", 64'(ch_count4), 64'd0);
        chk("ar_empty", 64'(empty4), 64'd1);
        chk("ar_full", 64'(full4), 64'd0);
        chk("ar_cycle", cycle_count4, 64'd0);
        do_reset();
        step();
        chk("ar_post_cycle", cycle_count4, 64'd1);
        chk("ar_post_count", 64'(count4), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
